// File: rtl/saber_seq_pkg.sv
// Shared definitions for the Saber command sequencer.
// Holds default field widths, the sequencer state encoding, reserved opcodes and a small
// instruction field helper. Instruction words are {we1, we0, cmd}, with the opcode in the
// low OPC_W bits of cmd.
package saber_seq_pkg;

  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefOpcW  = 5;
  localparam int unsigned DefLenW  = 16;
  localparam int unsigned DefPcW   = 8;
  localparam int unsigned DefTmoW  = 20;
  localparam int unsigned DefCmdW  = 3 * DefAddrW + DefOpcW;

  // Reserved opcodes: NOP/clear never stalls, HALT (with we0=we1=0) ends the program.
  localparam logic [DefOpcW-1:0] OPC_NOP  = 5'd0;
  localparam logic [DefOpcW-1:0] OPC_HALT = 5'd31;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait
  } seq_state_e;

  typedef struct packed {
    logic               we1;
    logic               we0;
    logic [DefCmdW-1:0] cmd;
  } instr_t;

  function automatic logic [DefOpcW-1:0] instr_opcode(input logic [DefCmdW-1:0] cmd);
    return cmd[DefOpcW-1:0];
  endfunction

endpackage

// File: rtl/saber_seq_iram.sv
// Program RAM for the sequencer: one write port, one synchronous read port.
// Ports:
//   clk    in   clock
//   we     in   write strobe
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, data appears on rdata one cycle later
//   rdata  out  registered read data
// Contents are not reset.
module saber_seq_iram #(
  parameter int unsigned AddrW = 8,
  parameter int unsigned DataW = 37
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [DataW-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem_q [2**AddrW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/saber_cmd_sequencer.sv
// Programmable command sequencer for the Saber compute core.
// Replays a program of {we1, we0, cmd} words from start_pc, driving the core's command
// interface, stalling on core_done after real instructions and stopping on HALT.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   prog_we/addr/wdata       program RAM write port (ignored while busy)
//   start, start_pc          1-cycle run request and entry address
//   abort                    drop the running program, back to idle
//   core_done                core finished the current opcode
//   command_in/we0/we1       command interface to the core
//   busy, done, error, pc    status: running, HALT pulse, sticky fault, program counter
module saber_cmd_sequencer
  import saber_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned OPC_W    = DefOpcW,
  parameter int unsigned LEN_W    = DefLenW,
  parameter int unsigned PC_W     = DefPcW,
  parameter int unsigned TMO_W    = DefTmoW,
  parameter int unsigned HALT_OPC = OPC_HALT,
  // Both field layouts describe the same word; they agree for legal parameter sets.
  localparam int unsigned CMD_W   = (3 * ADDR_W + OPC_W > 2 * LEN_W + 3) ?
                                    3 * ADDR_W + OPC_W : 2 * LEN_W + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [CMD_W+1:0]  prog_wdata,
  input  logic              start,
  input  logic [PC_W-1:0]   start_pc,
  input  logic              abort,
  input  logic              core_done,
  output logic [CMD_W-1:0]  command_in,
  output logic              command_we0,
  output logic              command_we1,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [PC_W-1:0]   pc
);

  // Timeout fires at the end of the (2**TMO_W-1)-th WAIT cycle.
  localparam logic [TMO_W-1:0] TmoLast = {{(TMO_W - 1){1'b1}}, 1'b0};

  seq_state_e         state_q;
  logic [PC_W-1:0]    pc_q;
  logic [CMD_W-1:0]   cmd_q;
  logic               we0_q, we1_q, busy_q, done_q, err_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               cdone_q;

  logic [CMD_W+1:0]   rdata;
  logic               i_we1, i_we0;
  logic [CMD_W-1:0]   i_cmd;
  logic               i_halt, i_waits, last_pc;

  saber_seq_iram #(
    .AddrW (PC_W),
    .DataW (CMD_W + 2)
  ) u_iram (
    .clk   (clk),
    .we    (prog_we & ~busy_q),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (pc_q),
    .rdata (rdata)
  );

  assign i_we1   = rdata[CMD_W+1];
  assign i_we0   = rdata[CMD_W];
  assign i_cmd   = rdata[CMD_W-1:0];
  assign i_halt  = (i_cmd == CMD_W'(HALT_OPC));
  assign i_waits = i_we0 && (i_cmd[OPC_W-1:0] != OPC_W'(OPC_NOP));
  assign last_pc = &pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cmd_q   <= '0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      cdone_q <= 1'b0;
    end else begin
      // Strobes and done are single-cycle pulses.
      we0_q  <= 1'b0;
      we1_q  <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              pc_q    <= start_pc;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= StFetch;
            end
          end
          StFetch: state_q <= StIssue;
          StIssue: begin
            if (i_we1 && i_we0) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else if (!i_we1 && !i_we0 && i_halt) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              cmd_q <= i_cmd;
              we1_q <= i_we1;
              we0_q <= i_we0;
              if (i_waits) begin
                tmo_q   <= '0;
                cdone_q <= 1'b0;
                state_q <= StWait;
              end else if (last_pc) begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end else begin
                pc_q    <= pc_q + PC_W'(1);
                state_q <= StFetch;
              end
            end
          end
          StWait: begin
            if (cdone_q) begin
              if (last_pc) begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end else begin
                pc_q    <= pc_q + PC_W'(1);
                state_q <= StFetch;
              end
            end else if (tmo_q == TmoLast) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
              // we0_q marks the strobe cycle; a done seen there belongs to older work.
              if (core_done && !we0_q) begin
                cdone_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign command_in  = cmd_q;
  assign command_we0 = we0_q;
  assign command_we1 = we1_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_saber_cmd_sequencer.sv
module tb_saber_cmd_sequencer;

  typedef struct packed {
    logic [1:0]  kind;  // 1: we1, 2: we0, 3: done
    logic [34:0] cmd;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [36:0] prog_wdata = '0;
  logic        start = 1'b0;
  logic [7:0]  start_pc = '0;
  logic        abort = 1'b0;
  logic        core_done = 1'b0;
  logic [34:0] command_in;
  logic        command_we0, command_we1, busy, done, error;
  logic [7:0]  pc;

  saber_cmd_sequencer #(.TMO_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .start       (start),
    .start_pc    (start_pc),
    .abort       (abort),
    .core_done   (core_done),
    .command_in  (command_in),
    .command_we0 (command_we0),
    .command_we1 (command_we1),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int ev_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n) ev_cnt <= ev_cnt + int'(command_we0) + int'(command_we1) + int'(done);

  ev_t exp_q[$];
  int  exp_total = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [1:0] kind, input logic [34:0] cmd);
    exp_q.push_back('{kind: kind, cmd: cmd});
    exp_total++;
  endtask

  task automatic load(input logic [7:0] a, input logic [36:0] w);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_wdata = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] spc, output int s);
    @(negedge clk);
    start = 1'b1; start_pc = spc; s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scoreboard consumer: waits for the next strobe/done and checks it against the queue.
  task automatic wait_event(input string name, output int c);
    ev_t        e;
    logic [1:0] k;
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (command_we0 || command_we1 || done) begin
        c = cyc;
        break;
      end
    end
    n_tests++;
    if (c < 0) begin
      n_fail++;
      $display("FAIL %s: no strobe or done within 200 cycles, required one", name);
    end else begin
      k = done ? 2'd3 : (command_we1 ? 2'd1 : 2'd2);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: event kind %0d with empty scoreboard, required none", name, k);
      end else begin
        e = exp_q.pop_front();
        if (k !== e.kind || (command_we0 && command_we1) ||
            (k != 2'd3 && command_in !== e.cmd)) begin
          n_fail++;
          $display("FAIL %s: got kind %0d we0 %b we1 %b cmd %h, required kind %0d cmd %h",
                   name, k, command_we0, command_we1, command_in, e.kind, e.cmd);
        end
      end
    end
  endtask

  task automatic check_quiet(input string name, input int n);
    int base;
    @(negedge clk); #1 base = ev_cnt;
    repeat (n) @(negedge clk);
    #1;
    n_tests++;
    if (ev_cnt !== base) begin
      n_fail++;
      $display("FAIL %s: %0d strobe/done events, required 0", name, ev_cnt - base);
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({command_we0, command_we1, busy, done, error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00000",
               {command_we0, command_we1, busy, done, error});
    end
    n_tests++;
    if (command_in !== 35'h0 || pc !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got cmd %h pc %0d, required 0 0", command_in, pc);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int s, c1, c2, c3, t;
    load(8'd0, 37'h1000200020);
    load(8'd1, 37'h08F8000F81);
    load(8'd2, 37'h000000001F);
    push_exp(2'd1, 35'h000200020);
    push_exp(2'd2, 35'h0F8000F81);
    push_exp(2'd3, 35'h0);
    do_start(8'd0, s);
    wait_event("basic_we1", c1);
    n_tests++;
    if (c1 !== s + 3) begin
      n_fail++; $display("FAIL basic_latency: strobe at %0d, required %0d", c1, s + 3);
    end
    wait_event("basic_we0", c2);
    n_tests++;
    if (c2 !== c1 + 2) begin
      n_fail++; $display("FAIL basic_throughput: we0 at %0d, required %0d", c2, c1 + 2);
    end
    repeat (3) @(negedge clk);
    core_done = 1'b1; t = cyc;
    @(negedge clk) core_done = 1'b0;
    wait_event("basic_done", c3);
    n_tests++;
    if (c3 !== t + 4 || busy !== 1'b0 || error !== 1'b0 || pc !== 8'd2) begin
      n_fail++;
      $display("FAIL basic_halt: done at %0d busy %b err %b pc %0d, required %0d 0 0 2",
               c3, busy, error, pc, t + 4);
    end
  endtask

  task automatic test_wait();
    int s, c1, c2, c3, t;
    load(8'd10, 37'h0923450021);
    load(8'd11, 37'h1000ABCDEF);
    load(8'd12, 37'h000000001F);
    push_exp(2'd2, 35'h123450021);
    push_exp(2'd1, 35'h000ABCDEF);
    push_exp(2'd3, 35'h0);
    do_start(8'd10, s);
    wait_event("wait_we0", c1);
    core_done = 1'b1;  // same cycle as the strobe: must be ignored
    @(negedge clk) core_done = 1'b0;
    repeat (48) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || command_we1 !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_stall: busy %b we1 %b, required 1 0", busy, command_we1);
    end
    @(negedge clk) core_done = 1'b1;
    t = cyc;
    @(negedge clk) core_done = 1'b0;
    wait_event("wait_we1", c2);
    n_tests++;
    if (c2 !== t + 4) begin
      n_fail++; $display("FAIL wait_resume: we1 at %0d, required %0d", c2, t + 4);
    end
    wait_event("wait_done", c3);
  endtask

  task automatic test_nop_nowait();
    int s, c1, c2, c3, t;
    load(8'd20, 37'h0800000040);
    load(8'd21, 37'h0800000043);
    load(8'd22, 37'h000000001F);
    push_exp(2'd2, 35'h000000040);
    push_exp(2'd2, 35'h000000043);
    push_exp(2'd3, 35'h0);
    do_start(8'd20, s);
    wait_event("nop_we0_a", c1);
    wait_event("nop_we0_b", c2);
    n_tests++;
    if (c2 !== c1 + 2) begin
      n_fail++; $display("FAIL nop_no_wait: second we0 at %0d, required %0d", c2, c1 + 2);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL op3_waits: busy %b, required 1", busy);
    end
    @(negedge clk) core_done = 1'b1;
    t = cyc;
    @(negedge clk) core_done = 1'b0;
    wait_event("nop_done", c3);
    n_tests++;
    if (c3 !== t + 4) begin
      n_fail++; $display("FAIL nop_done_time: done at %0d, required %0d", c3, t + 4);
    end
  endtask

  task automatic test_timeout();
    int s, c;
    load(8'd30, 37'h0800000022);
    load(8'd31, 37'h000000001F);
    push_exp(2'd2, 35'h000000022);
    do_start(8'd30, s);
    wait_event("tmo_we0", c);
    repeat (62) @(negedge clk);
    n_tests++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL tmo_early: err %b busy %b, required 0 1", error, busy);
    end
    @(negedge clk);
    n_tests++;
    if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_fire: err %b busy %b done %b, required 1 0 0", error, busy, done);
    end
    check_quiet("tmo_quiet", 5);
  endtask

  task automatic test_overrun();
    int s;
    for (int i = 0; i < 256; i++) load(8'(i), {2'b00, 35'(i + 256)});
    do_start(8'd0, s);
    n_tests++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_clears_err: err %b busy %b, required 0 1", error, busy);
    end
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || error !== 1'b1 || pc !== 8'd255 || command_in !== 35'h1FF) begin
      n_fail++;
      $display("FAIL overrun: busy %b err %b pc %0d cmd %h, required 0 1 255 1ff",
               busy, error, pc, command_in);
    end
  endtask

  task automatic test_abort();
    int s, c;
    load(8'd0, 37'h0800000061);
    load(8'd1, 37'h000000001F);
    load(8'd2, 37'h10000007FF);
    push_exp(2'd2, 35'h000000061);
    do_start(8'd0, s);
    wait_event("abort_we0", c);
    repeat (3) @(negedge clk);
    start = 1'b1; start_pc = 8'd2;
    @(negedge clk) start = 1'b0;
    n_tests++;
    if (pc !== 8'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_while_busy: pc %0d busy %b, required 0 1", pc, busy);
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || command_we0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wait: busy %b done %b err %b we0 %b, required 0 0 0 0",
               busy, done, error, command_we0);
    end
    check_quiet("abort_wait_quiet", 6);
    do_start(8'd2, s);
    @(negedge clk) abort = 1'b1;  // ISSUE cycle of the we1 word
    @(negedge clk) abort = 1'b0;
    n_tests++;
    if (command_we1 !== 1'b0 || busy !== 1'b0 || command_in !== 35'h61) begin
      n_fail++;
      $display("FAIL abort_issue: we1 %b busy %b cmd %h, required 0 0 61",
               command_we1, busy, command_in);
    end
    check_quiet("abort_issue_quiet", 4);
  endtask

  task automatic test_reset_mid();
    int s, c, t;
    push_exp(2'd2, 35'h000000061);
    do_start(8'd0, s);
    wait_event("rst_we0", c);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, command_we0, command_we1, done, error} !== 5'b0 ||
        command_in !== 35'h0 || pc !== 8'h0) begin
      n_fail++;
      $display("FAIL async_reset: busy %b we0 %b cmd %h pc %0d, required 0 0 0 0",
               busy, command_we0, command_in, pc);
    end
    @(negedge clk) rst_n = 1'b1;
    push_exp(2'd2, 35'h000000061);
    push_exp(2'd3, 35'h0);
    do_start(8'd0, s);
    wait_event("rerun_we0", c);
    n_tests++;
    if (c !== s + 3) begin
      n_fail++; $display("FAIL rerun_latency: strobe at %0d, required %0d", c, s + 3);
    end
    repeat (2) @(negedge clk);
    core_done = 1'b1; t = cyc;
    @(negedge clk) core_done = 1'b0;
    wait_event("rerun_done", c);
    n_tests++;
    if (c !== t + 4 || pc !== 8'd1) begin
      n_fail++; $display("FAIL rerun_halt: done at %0d pc %0d, required %0d 1", c, pc, t + 4);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_nop_nowait();
    test_timeout();
    test_overrun();
    test_abort();
    test_reset_mid();
    @(negedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0 || ev_cnt !== exp_total) begin
      n_fail++;
      $display("FAIL scoreboard_end: %0d pending, %0d events, required 0 pending %0d events",
               exp_q.size(), ev_cnt, exp_total);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
